// File: rtl/serial_transmitter.sv
// UART-style 8N1 serial transmitter with a valid/ready byte interface and a fixed baud divider.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module serial_transmitter #(
    parameter int CLOCKS_PER_BIT = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_data_available,
    output logic       tx_ready,
    output logic       serial_tx
);

    localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_n;
    logic          bit_end;
    logic          accept;

    assign bit_end  = (cnt == LAST);
    // Ready only in the final STOP cycle so a new frame can start with no idle gap.
    assign tx_ready = (state == IDLE) || ((state == STOP) && bit_end);
    assign accept   = tx_data_available && tx_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            serial_tx <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            serial_tx <= tx_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        tx_n      = serial_tx;
        if (state != IDLE) cnt_n = bit_end ? '0 : cnt + CW'(1);
        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_n = tx_data;
                    cnt_n   = '0;
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_idx_n = 3'd0;
                    tx_n      = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_n = PARITY;
                        tx_n    = ^shreg;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = shreg[bit_idx + 3'd1];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (accept) begin
                        shreg_n = tx_data;
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench for serial_transmitter with a short bit period; follows SERIAL_TX_PARITY_EN for frame length.
module tb_serial_transmitter;

    localparam int CPB = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_data_available = 1'b0;
    logic       tx_ready;
    logic       serial_tx;

    int checks = 0;
    int failures = 0;

    serial_transmitter #(.CLOCKS_PER_BIT(CPB)) dut (
        .clock(clock),
        .reset(reset),
        .tx_data(tx_data),
        .tx_data_available(tx_data_available),
        .tx_ready(tx_ready),
        .serial_tx(serial_tx)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] fb;
        fb = '1;
        fb[0] = 1'b0;
        fb[8:1] = b;
`ifdef SERIAL_TX_PARITY_EN
        fb[9] = ^b;
`endif
        return fb;
    endfunction

    task automatic send(input logic [7:0] b);
        tx_data = b;
        tx_data_available = 1'b1;
        @(negedge clock);
        tx_data_available = 1'b0;
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            chk({tag, "_tx"}, serial_tx, 8'd1);
            chk({tag, "_ready"}, tx_ready, 8'd1);
            @(negedge clock);
        end
    endtask

    // Checks one frame sample by sample starting at the first cycle after the accept edge.
    task automatic run_frame(input logic [7:0] b, input int poke_at, input logic poke_av,
                             input logic [7:0] poke_d, input logic nxt_av, input logic [7:0] nxt_d);
        logic [10:0] fb;
        fb = frame_bits(b);
        for (int i = 0; i < NB * CPB; i++) begin
            chk("frame_tx", serial_tx, 8'(fb[i / CPB]));
            chk("frame_ready", tx_ready, 8'(i == NB * CPB - 1));
            if (i == poke_at) begin
                tx_data_available = poke_av;
                tx_data = poke_d;
            end
            if (i == poke_at + 1) tx_data_available = 1'b0;
            if (i == NB * CPB - 1) begin
                tx_data_available = nxt_av;
                tx_data = nxt_d;
            end
            @(negedge clock);
        end
        tx_data_available = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("reset_tx", serial_tx, 8'd1);
        chk("reset_ready", tx_ready, 8'd1);
        idle(5 * CPB, "idle");

        // 0xAB with tx_data changed just after accept, then 0x11 back-to-back
        send(8'hAB);
        run_frame(8'hAB, 1, 1'b0, 8'h00, 1'b1, 8'h11);
        // 0x11 with a request mid-frame that must be dropped
        run_frame(8'h11, 4 * CPB, 1'b1, 8'h55, 1'b0, 8'h00);
        idle(3 * CPB, "after_drop");

        // Reset during data bit 3, with a simultaneous request that must lose
        send(8'hC3);
        repeat (4 * CPB + 2) @(negedge clock);
        chk("bit3_tx", serial_tx, 8'd0);
        chk("bit3_ready", tx_ready, 8'd0);
        reset = 1'b1;
        tx_data = 8'hFF;
        tx_data_available = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tx_data_available = 1'b0;
        chk("midreset_tx", serial_tx, 8'd1);
        chk("midreset_ready", tx_ready, 8'd1);
        idle(2 * CPB, "post_reset");

        send(8'h5A);
        run_frame(8'h5A, -10, 1'b0, 8'h00, 1'b0, 8'h00);
        idle(2 * CPB, "final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
